// File: rtl/pc_gen_pkg.sv
// Shared fetch-PC types: FSM states, next-PC select and reset default.
// XLEN follows `MXLEN (32 when not supplied by the build).
`ifndef MXLEN
`define MXLEN 32
`endif

package pc_gen_pkg;

  localparam int XLEN = `MXLEN;

  localparam logic [XLEN-1:0] RESET_PC_DEF =
    XLEN'(32'h8000_0000);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD
  } state_e;

  typedef enum logic [2:0] {
    SEL_FLUSH,
    SEL_PEND,
    SEL_PRED,
    SEL_SEQ,
    SEL_HOLDPC
  } npc_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-PC bundle between backend/predictor/I-cache and pc_gen.
// slave = pc_gen side, master = environment side.
interface pc_gen_if;

  logic               i_flush;
  logic [`MXLEN-1:0]  i_flush_pc;
  logic               i_upre_jump;
  logic [`MXLEN-1:0]  i_upre_target;
  logic               i_fetch_ready;
  logic [`MXLEN-1:0]  o_npc;
  logic [`MXLEN-1:0]  o_cpc;
  logic               o_pc_valid;
  logic               o_redirect;

  modport slave (
    input  i_flush,
    input  i_flush_pc,
    input  i_upre_jump,
    input  i_upre_target,
    input  i_fetch_ready,
    output o_npc,
    output o_cpc,
    output o_pc_valid,
    output o_redirect
  );

  modport master (
    output i_flush,
    output i_flush_pc,
    output i_upre_jump,
    output i_upre_target,
    output i_fetch_ready,
    input  o_npc,
    input  o_cpc,
    input  o_pc_valid,
    input  o_redirect
  );

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry pending redirect target.
// Capture while stalled; consume or clear empties it.
module pc_redirect_buf
  import pc_gen_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_capture,
  input  logic            i_consume,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_target,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] target_d;
  logic [XLEN-1:0] target_q;

  // clear/consume beat capture so a flush never leaves a stale target
  always_comb begin
    target_d = target_q;
    if (i_clear || i_consume) begin
      target_d = '0;
    end else if (i_capture) begin
      target_d = i_target;
    end
  end

  // pending target register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      target_q <= '0;
    end else begin
      target_q <= target_d;
    end
  end

  assign o_target = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: flush > pending > prediction > sequential > hold.
// Optional PC_GEN_PERF_EN adds saturating flush/prediction counters.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEF,
  parameter int              FETCH_BYTES = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  pc_gen_if.slave     bus
`ifdef PC_GEN_PERF_EN
  ,
  output logic [31:0] o_flush_cnt,
  output logic [31:0] o_pred_cnt
`endif
);

  localparam logic [XLEN-1:0] STRIDE = XLEN'(FETCH_BYTES);
  localparam logic [XLEN-1:0] BLK_MASK = ~(STRIDE - 1'b1);

  state_e          state_d, state_q;
  logic [XLEN-1:0] cpc_d, cpc_q;
  logic            valid_d, valid_q;
  logic            redir_d, redir_q;
  npc_sel_e        sel;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] pend_pc;
  logic            capture;
  logic            consume;
  logic            fire;

  assign fire = valid_q && bus.i_fetch_ready;

  // next-PC select, FSM next state and pending-buffer control
  always_comb begin
    sel     = SEL_HOLDPC;
    state_d = state_q;
    capture = 1'b0;
    consume = 1'b0;
    if (bus.i_flush) begin
      sel = SEL_FLUSH;
    end else if (state_q == ST_HOLD && bus.i_fetch_ready) begin
      sel = SEL_PEND;
    end else if (fire && bus.i_upre_jump) begin
      sel = SEL_PRED;
    end else if (fire) begin
      sel = SEL_SEQ;
    end
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (!bus.i_flush && valid_q &&
            !bus.i_fetch_ready && bus.i_upre_jump) begin
          capture = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        consume = bus.i_fetch_ready;
        if (bus.i_fetch_ready || bus.i_flush) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // next-PC mux
  always_comb begin
    npc = cpc_q;
    unique case (sel)
      SEL_FLUSH:  npc = bus.i_flush_pc;
      SEL_PEND:   npc = pend_pc;
      SEL_PRED:   npc = bus.i_upre_target;
      SEL_SEQ:    npc = (cpc_q & BLK_MASK) + STRIDE;
      SEL_HOLDPC: npc = cpc_q;
      default:    npc = cpc_q;
    endcase
  end

  // registered-state next values
  always_comb begin
    cpc_d   = npc;
    valid_d = 1'b1;
    redir_d = (sel == SEL_FLUSH) || (sel == SEL_PEND) ||
              (sel == SEL_PRED);
  end

  // fetch state registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_BOOT;
      cpc_q   <= RESET_PC;
      valid_q <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cpc_q   <= cpc_d;
      valid_q <= valid_d;
      redir_q <= redir_d;
    end
  end

  pc_redirect_buf u_buf (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_capture (capture),
    .i_consume (consume),
    .i_clear   (bus.i_flush),
    .i_target  (bus.i_upre_target),
    .o_target  (pend_pc)
  );

  assign bus.o_npc      = i_rstn ? npc : RESET_PC;
  assign bus.o_cpc      = cpc_q;
  assign bus.o_pc_valid = valid_q;
  assign bus.o_redirect = redir_q;

`ifdef PC_GEN_PERF_EN
  logic [31:0] flush_cnt_d, flush_cnt_q;
  logic [31:0] pred_cnt_d, pred_cnt_q;

  // saturating event counters
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    pred_cnt_d  = pred_cnt_q;
    if (bus.i_flush && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
    if ((sel == SEL_PEND || sel == SEL_PRED) && !(&pred_cnt_q)) begin
      pred_cnt_d = pred_cnt_q + 32'd1;
    end
  end

  // counter registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      flush_cnt_q <= '0;
      pred_cnt_q  <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      pred_cnt_q  <= pred_cnt_d;
    end
  end

  assign o_flush_cnt = flush_cnt_q;
  assign o_pred_cnt  = pred_cnt_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset, sequential, prediction, stall,
// flush, wrap, unaligned, boot flush and mid-HOLD reset.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  pc_gen_if bus ();

`ifdef PC_GEN_PERF_EN
  logic [31:0] flush_cnt;
  logic [31:0] pred_cnt;
`endif

  pc_gen dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
`ifdef PC_GEN_PERF_EN
    ,
    .o_flush_cnt (flush_cnt),
    .o_pred_cnt  (pred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cpc(input string nm, input logic [31:0] exp);
    checks++;
    if (bus.o_cpc !== exp) begin
      errors++;
      $display("FAIL %s cpc got %h exp %h", nm, bus.o_cpc, exp);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus.i_flush = 1'b1;
    bus.i_flush_pc = 32'h1234_5678;
    bus.i_upre_jump = 1'b0;
    bus.i_upre_target = '0;
    bus.i_fetch_ready = 1'b1;
    step();
    step();
    chk_cpc("reset", 32'h8000_0000);
    checks++;
    if (bus.o_npc !== 32'h8000_0000) begin
      errors++;
      $display("FAIL reset_npc got %h exp 80000000", bus.o_npc);
    end
    checks++;
    if (bus.o_pc_valid !== 1'b0 || bus.o_redirect !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b exp 00",
               bus.o_pc_valid, bus.o_redirect);
    end
    bus.i_flush = 1'b0;
    rstn = 1'b1;
    #1;
  endtask

  task automatic test_seq;
    checks++;
    if (bus.o_npc !== 32'h8000_0000 || bus.o_pc_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot got npc %h v %b exp 80000000 0",
               bus.o_npc, bus.o_pc_valid);
    end
    step();
    chk_cpc("seq0", 32'h8000_0000);
    checks++;
    if (bus.o_pc_valid !== 1'b1 || bus.o_redirect !== 1'b0) begin
      errors++;
      $display("FAIL seq0_flags got %b%b exp 10",
               bus.o_pc_valid, bus.o_redirect);
    end
    checks++;
    if (bus.o_npc !== 32'h8000_0008) begin
      errors++;
      $display("FAIL seq0_npc got %h exp 80000008", bus.o_npc);
    end
    step();
    chk_cpc("seq1", 32'h8000_0008);
    step();
    chk_cpc("seq2", 32'h8000_0010);
    checks++;
    if (bus.o_redirect !== 1'b0) begin
      errors++;
      $display("FAIL seq2_redir got %b exp 0", bus.o_redirect);
    end
  endtask

  task automatic test_pred;
    bus.i_upre_jump = 1'b1;
    bus.i_upre_target = 32'h8000_0100;
    #1;
    checks++;
    if (bus.o_npc !== 32'h8000_0100) begin
      errors++;
      $display("FAIL pred_npc got %h exp 80000100", bus.o_npc);
    end
    step();
    bus.i_upre_jump = 1'b0;
    chk_cpc("pred", 32'h8000_0100);
    checks++;
    if (bus.o_redirect !== 1'b1) begin
      errors++;
      $display("FAIL pred_redir got %b exp 1", bus.o_redirect);
    end
    step();
    chk_cpc("pred_seq", 32'h8000_0108);
  endtask

  task automatic test_stall;
    bus.i_fetch_ready = 1'b0;
    bus.i_upre_jump = 1'b1;
    bus.i_upre_target = 32'h8000_0200;
    #1;
    checks++;
    if (bus.o_npc !== 32'h8000_0108) begin
      errors++;
      $display("FAIL stall_npc got %h exp 80000108", bus.o_npc);
    end
    step();
    bus.i_upre_target = 32'h8000_0300;
    chk_cpc("stall1", 32'h8000_0108);
    checks++;
    if (dut.state_q !== ST_HOLD) begin
      errors++;
      $display("FAIL stall_state got %0d exp %0d",
               dut.state_q, ST_HOLD);
    end
    step();
    step();
    chk_cpc("stall3", 32'h8000_0108);
    bus.i_fetch_ready = 1'b1;
    #1;
    checks++;
    if (bus.o_npc !== 32'h8000_0200) begin
      errors++;
      $display("FAIL pend_npc got %h exp 80000200", bus.o_npc);
    end
    step();
    bus.i_upre_jump = 1'b0;
    chk_cpc("pend", 32'h8000_0200);
    checks++;
    if (bus.o_redirect !== 1'b1 || dut.state_q !== ST_RUN) begin
      errors++;
      $display("FAIL pend_flags got r %b st %0d exp 1 %0d",
               bus.o_redirect, dut.state_q, ST_RUN);
    end
    step();
    chk_cpc("pend_seq", 32'h8000_0208);
  endtask

  task automatic test_flush_hold;
    bus.i_fetch_ready = 1'b0;
    bus.i_upre_jump = 1'b1;
    bus.i_upre_target = 32'h8000_0400;
    step();
    bus.i_flush = 1'b1;
    bus.i_flush_pc = 32'h8000_1000;
    #1;
    checks++;
    if (bus.o_npc !== 32'h8000_1000) begin
      errors++;
      $display("FAIL fh_npc got %h exp 80001000", bus.o_npc);
    end
    step();
    chk_cpc("fh", 32'h8000_1000);
    checks++;
    if (bus.o_redirect !== 1'b1 || dut.state_q !== ST_RUN) begin
      errors++;
      $display("FAIL fh_flags got r %b st %0d exp 1 %0d",
               bus.o_redirect, dut.state_q, ST_RUN);
    end
    bus.i_flush = 1'b0;
    bus.i_upre_jump = 1'b0;
    bus.i_fetch_ready = 1'b1;
    step();
    chk_cpc("fh_seq", 32'h8000_1008);
    checks++;
    if (bus.o_redirect !== 1'b0) begin
      errors++;
      $display("FAIL fh_seq_redir got %b exp 0", bus.o_redirect);
    end
  endtask

  task automatic test_wrap_unaligned;
    bus.i_flush = 1'b1;
    bus.i_flush_pc = 32'hFFFF_FFF8;
    step();
    bus.i_flush = 1'b0;
    chk_cpc("wrap0", 32'hFFFF_FFF8);
    step();
    chk_cpc("wrap1", 32'h0000_0000);
    bus.i_flush = 1'b1;
    bus.i_flush_pc = 32'h8000_0004;
    step();
    bus.i_flush = 1'b0;
    chk_cpc("unal0", 32'h8000_0004);
    #1;
    checks++;
    if (bus.o_npc !== 32'h8000_0008) begin
      errors++;
      $display("FAIL unal_npc got %h exp 80000008", bus.o_npc);
    end
    step();
    chk_cpc("unal1", 32'h8000_0008);
  endtask

  task automatic test_flush_boot;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_flush_pc = 32'h8000_2000;
    step();
    bus.i_flush = 1'b0;
    chk_cpc("fboot", 32'h8000_2000);
    checks++;
    if (bus.o_redirect !== 1'b1 || bus.o_pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL fboot_flags got %b%b exp 11",
               bus.o_redirect, bus.o_pc_valid);
    end
  endtask

  task automatic test_reset_hold;
    bus.i_fetch_ready = 1'b0;
    bus.i_upre_jump = 1'b1;
    bus.i_upre_target = 32'h8000_0500;
    step();
    rstn = 1'b0;
    #1;
    chk_cpc("rhold", 32'h8000_0000);
    checks++;
    if (bus.o_pc_valid !== 1'b0 || bus.o_redirect !== 1'b0 ||
        dut.state_q !== ST_BOOT) begin
      errors++;
      $display("FAIL rhold_flags got v%b r%b st %0d exp 0 0 %0d",
               bus.o_pc_valid, bus.o_redirect, dut.state_q, ST_BOOT);
    end
    bus.i_upre_jump = 1'b0;
    bus.i_fetch_ready = 1'b1;
    rstn = 1'b1;
`ifdef PC_GEN_PERF_EN
    checks++;
    if (flush_cnt !== 32'd0 || pred_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_rst got %0d %0d exp 0 0",
               flush_cnt, pred_cnt);
    end
`endif
    step();
    chk_cpc("rhold_boot", 32'h8000_0000);
    step();
    chk_cpc("rhold_seq", 32'h8000_0008);
`ifdef PC_GEN_PERF_EN
    bus.i_flush = 1'b1;
    bus.i_flush_pc = 32'h8000_3000;
    step();
    bus.i_flush = 1'b0;
    bus.i_upre_jump = 1'b1;
    bus.i_upre_target = 32'h8000_4000;
    step();
    bus.i_upre_jump = 1'b0;
    checks++;
    if (flush_cnt !== 32'd1 || pred_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_cnt got %0d %0d exp 1 1",
               flush_cnt, pred_cnt);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_seq();
    test_pred();
    test_stall();
    test_flush_hold();
    test_wrap_unaligned();
    test_flush_boot();
    test_reset_hold();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Fetch PC generator sitting directly upstream of the micro-predictor; produces the next-PC (nPc) and current-PC (cPc) pair that the predictor and I-cache consume.
- Selects the next fetch address from backend flush, micro-predictor redirect, or sequential fetch-block increment.
- Holds the PC on I-cache back-pressure and buffers one prediction redirect that arrives while stalled.
- Guarantees cPc equals the previous cycle's nPc at every clock edge after reset.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- FETCH_BYTES, 8, fetch-block size in bytes; power of two; sequential stride.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset.
- i_flush  in  1  backend redirect (mispredict/exception); highest priority.
- i_flush_pc  in  `MXLEN  backend redirect target.
- i_upre_jump  in  1  micro-predictor taken prediction for cPc.
- i_upre_target  in  `MXLEN  micro-predictor target.
- i_fetch_ready  in  1  I-cache accepts cPc this cycle.
- o_npc  out  `MXLEN  next PC (combinational); feeds predictor read port.
- o_cpc  out  `MXLEN  registered current fetch PC.
- o_pc_valid  out  1  cPc is a valid fetch request.
- o_redirect  out  1  cPc in this cycle resulted from a non-sequential redirect (flush or prediction).

Behaviour:
- Reset i_rstn is asynchronous, active-low; clock is i_clk.
- Reset values:
  - state=BOOT; o_cpc=RESET_PC; o_pc_valid=0; o_redirect=0; pending register cleared.
  - o_npc=RESET_PC while in reset.
- States:
  - BOOT: one cycle after reset release. o_npc=RESET_PC. Always moves to RUN; o_pc_valid becomes 1.
  - RUN: normal fetch.
  - HOLD: a prediction was captured while i_fetch_ready=0.
- o_npc priority, evaluated every cycle (first match wins):
  1. i_flush: i_flush_pc.
  2. State HOLD and i_fetch_ready: pending target.
  3. o_pc_valid, i_fetch_ready and i_upre_jump: i_upre_target.
  4. o_pc_valid and i_fetch_ready: (o_cpc with low log2(FETCH_BYTES) bits cleared) + FETCH_BYTES. Wraps modulo 2^MXLEN, no carry out.
  5. Otherwise: o_cpc (hold).
- Prediction while stalled: if o_pc_valid and !i_fetch_ready and i_upre_jump and !i_flush in RUN, capture i_upre_target into the pending register and go to HOLD.
  - Further predictions in HOLD are ignored: cPc is unchanged, so the predictor output is stale.
- HOLD exit: leave to RUN on i_fetch_ready or i_flush; i_flush discards the pending target.
- Register update: o_cpc <= o_npc every cycle in RUN/HOLD, so cPc == $past(nPc) always.
- o_redirect is registered: 1 in the cycle after case 1, 2 or 3 was selected, else 0.
- Flush in the same cycle as prediction or stall: flush wins, pending is cleared, next state RUN.
- Flush during BOOT: takes effect; o_cpc=i_flush_pc at the next edge.
- Reset mid-operation: returns immediately to the reset values above; the pending target is lost.
- Latency:
  - Redirect inputs appear on o_npc in the same cycle (combinational) and on o_cpc one cycle later.
  - A stalled prediction takes effect in the first ready cycle.

Optional Feature:
- Macro: PC_GEN_PERF_EN.
- Defined: adds outputs o_flush_cnt and o_pred_cnt, each 32 bits, reset 0.
  - o_flush_cnt counts cycles with i_flush.
  - o_pred_cnt counts redirects taken via case 2 or case 3.
  - Both saturate at all-ones.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared bpu package holds:
  - the state enum (BOOT, RUN, HOLD);
  - a typedef for the npc-select encoding (FLUSH, PEND, PRED, SEQ, HOLDPC);
  - the RESET_PC default constant.
- One sub-module is natural: pc_redirect_buf, the single-entry pending-target register with capture/consume/clear.

Test Plan:
- Reset release, i_fetch_ready=1, no prediction: o_cpc sequence 8000_0000, 8000_0008, 8000_0010; o_pc_valid=1 from the second cycle; o_redirect=0.
- At o_cpc=8000_0010, i_upre_jump=1 with target 8000_0100: o_npc=8000_0100 in the same cycle; next o_cpc=8000_0100 with o_redirect=1.
- i_fetch_ready=0 for 3 cycles with prediction to 8000_0200 on the first: o_cpc holds; state HOLD. On ready, o_npc=8000_0200.
- i_flush with i_flush_pc=8000_1000 while in HOLD and i_upre_jump=1: o_cpc becomes 8000_1000; pending discarded; never fetch 8000_0200.
- o_cpc=FFFF_FFF8 sequential: next o_cpc=0000_0000. Unaligned flush to 8000_0004 then sequential: 8000_0004 then 8000_0008.
- Assert nReset mid-HOLD: outputs return to reset values immediately. With PC_GEN_PERF_EN, counters read 0 afterwards and increment per flush/prediction.
